// File: rtl/duc_if.sv
// Baseband I/Q valid/ready channel between the TX source and the up-converter.
interface duc_if #(
  parameter int ISZ = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [ISZ-1:0] in_i;
  logic signed [ISZ-1:0] in_q;

  modport master (output in_valid, in_i, in_q, input in_ready);
  modport slave  (input in_valid, in_i, in_q, output in_ready);
endinterface

// File: rtl/duc.sv
// Digital up-converter: I/Q hold register, x32 three-stage CIC interpolator,
// NCO mixer producing one saturated real sample per clock.
module duc #(
  parameter int ISZ  = 16,
  parameter int OSZ  = 16,
  parameter int FSZ  = 26,
  parameter int PSZ  = 10,
  parameter int N    = 3,
  parameter int RLOG = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  duc_if.slave                  bb,
  input  logic [FSZ-1:0]        lo_freq,
  input  logic                  iq_swap,
  output logic                  underflow,
  output logic signed [OSZ-1:0] out
);
  localparam int W    = ISZ + N * RLOG;
  localparam int TLSB = (N - 1) * RLOG;
  localparam int RSZ  = 16;
  localparam int PW   = ISZ + RSZ;
  localparam int DW   = PW + 1;
  localparam int QTR  = 2 ** (PSZ - 2);
  localparam logic signed [DW-1:0] OMAX = DW'(2 ** (OSZ - 1) - 1);
  localparam logic signed [DW-1:0] OMIN = -OMAX - DW'(1);

  // Quarter-wave folded Taylor series keeps every entry exactly round(A*sin).
  function automatic logic signed [RSZ-1:0] sin_entry(input int k);
    int  m;
    int  v;
    bit  neg;
    real ang, term, acc;
    m   = k % (2 ** PSZ);
    neg = (m >= 2 * QTR);
    if (neg) m = m - 2 * QTR;
    if (m > QTR) m = 2 * QTR - m;
    ang  = 3.14159265358979323846 * real'(m) / real'(2 * QTR);
    term = ang;
    acc  = ang;
    for (int n = 1; n < 13; n++) begin
      term = -term * ang * ang / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    v = int'(real'(2 ** (RSZ - 1) - 1) * acc);
    return neg ? RSZ'(-v) : RSZ'(v);
  endfunction

  logic signed [RSZ-1:0] sin_rom [2**PSZ];
  for (genvar k = 0; k < 2 ** PSZ; k++) begin : g_rom
    assign sin_rom[k] = sin_entry(k);
  end

  logic [RLOG-1:0]       slot;
  logic                  strobe, strobe_d;
  logic                  hold_full, hold_full_nx, accept;
  logic signed [ISZ-1:0] hold_i, hold_q;

  // Index 0 is the I channel, index 1 the Q channel.
  logic signed [W-1:0]   x        [2];
  logic signed [W-1:0]   cx       [2][N];
  logic signed [W-1:0]   dly      [2][N];
  logic signed [W-1:0]   comb_out [2];
  logic signed [W-1:0]   integ    [2][N];
  logic signed [ISZ-1:0] trim     [2];

  logic [FSZ-1:0]        phase;
  logic [PSZ-1:0]        idx;
  logic signed [RSZ-1:0] sin_r, cos_r;
  logic signed [PW-1:0]  prod_i, prod_q;
  logic signed [DW-1:0]  diff, shr;

  assign strobe = (slot == {RLOG{1'b1}});
  assign idx    = phase[FSZ-1 -: PSZ];
  assign diff   = DW'(prod_i) - DW'(prod_q);
  assign shr    = diff >>> (RSZ - 1);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    accept       = bb.in_valid & bb.in_ready;
    hold_full_nx = hold_full;
    if (strobe && hold_full) hold_full_nx = 1'b0;
    if (accept)              hold_full_nx = 1'b1;
    x[0] = '0;
    x[1] = '0;
    if (hold_full) begin
      x[0] = W'(iq_swap ? hold_q : hold_i);
      x[1] = W'(iq_swap ? hold_i : hold_q);
    end
    for (int c = 0; c < 2; c++) begin
      cx[c][0] = x[c] - dly[c][0];
      for (int s = 1; s < N; s++) cx[c][s] = cx[c][s-1] - dly[c][s];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot        <= '0;
      strobe_d    <= 1'b0;
      hold_full   <= 1'b0;
      bb.in_ready <= 1'b1;
      hold_i      <= '0;
      hold_q      <= '0;
      underflow   <= 1'b0;
    end else begin
      // NOTE: state updates use <= so every register samples pre-edge values.
      slot        <= slot + RLOG'(1);
      strobe_d    <= strobe;
      hold_full   <= hold_full_nx;
      bb.in_ready <= ~hold_full_nx;
      underflow   <= strobe & ~hold_full;
      if (accept) begin
        hold_i <= bb.in_i;
        hold_q <= bb.in_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: delay lines and integrators are cleared too; a mid-stream reset must not leave stale CIC state.
      for (int c = 0; c < 2; c++) begin
        for (int s = 0; s < N; s++) begin
          dly[c][s]   <= '0;
          integ[c][s] <= '0;
        end
        comb_out[c] <= '0;
        trim[c]     <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (strobe) begin
          dly[c][0] <= x[c];
          for (int s = 1; s < N; s++) dly[c][s] <= cx[c][s-1];
          comb_out[c] <= cx[c][N-1];
        end
        // Zero-stuffing: the comb result enters the integrators for one cycle only.
        integ[c][0] <= integ[c][0] + (strobe_d ? comb_out[c] : '0);
        for (int s = 1; s < N; s++) integ[c][s] <= integ[c][s] + integ[c][s-1];
        trim[c] <= integ[c][N-1][TLSB +: ISZ];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase  <= '0;
      sin_r  <= '0;
      cos_r  <= '0;
      prod_i <= '0;
      prod_q <= '0;
      out    <= '0;
    end else begin
      phase  <= phase + lo_freq;
      sin_r  <= sin_rom[idx];
      cos_r  <= sin_rom[idx + PSZ'(QTR)];
      prod_i <= PW'(trim[0]) * PW'(cos_r);
      prod_q <= PW'(trim[1]) * PW'(sin_r);
      if (shr > OMAX)      out <= OMAX[OSZ-1:0];
      else if (shr < OMIN) out <= OMIN[OSZ-1:0];
      else                 out <= shr[OSZ-1:0];
    end
  end
endmodule

// File: tb/tb_duc.sv
// Directed bench for duc: steady-state vector table plus hand-written
// reset, handshake, underflow and decay sequences.
module tb_duc;
  localparam int ISZ = 16;
  localparam int OSZ = 16;
  localparam int FSZ = 26;
  localparam int NV  = 6;

  logic                  clk     = 1'b0;
  logic                  reset   = 1'b1;
  logic [FSZ-1:0]        lo_freq = '0;
  logic                  iq_swap = 1'b0;
  logic                  underflow;
  logic signed [OSZ-1:0] out;

  duc_if #(.ISZ(ISZ)) bb ();

  duc dut (
    .clk      (clk),
    .reset    (reset),
    .bb       (bb),
    .lo_freq  (lo_freq),
    .iq_swap  (iq_swap),
    .underflow(underflow),
    .out      (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                 name;
    logic [FSZ-1:0]        f;
    logic                  swap;
    logic signed [ISZ-1:0] i;
    logic signed [ISZ-1:0] q;
    logic [7:0][15:0]      exp;   // out expected at phase step (cyc-3) mod 8
  } vec_t;

  vec_t vecs [NV];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    cyc   = 0;
    reset = 1'b0;
  endtask

  function automatic logic [7:0][15:0] seq8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][15:0] r;
    r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
    r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
    return r;
  endfunction

  initial begin
    int               uf_cnt, rdy_low, s0;
    logic signed [15:0] e16;

    vecs[0] = '{"dc",       26'h0000000, 1'b0, 16'sh4000, 16'sh0000,
                seq8(16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383)};
    vecs[1] = '{"fs4",      26'h1000000, 1'b0, 16'sh4000, 16'sh0000,
                seq8(16383, 0, -16384, 0, 16383, 0, -16384, 0)};
    vecs[2] = '{"swap_on",  26'h0000000, 1'b1, 16'sh0000, 16'sh4000,
                seq8(16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383)};
    vecs[3] = '{"swap_off", 26'h0000000, 1'b0, 16'sh0000, 16'sh4000,
                seq8(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[4] = '{"sat",      26'h0800000, 1'b0, 16'sh7fff, 16'sh8000,
                seq8(32766, 32767, 32767, 0, -32767, -32768, -32767, -1)};
    vecs[5] = '{"dc_neg",   26'h0000000, 1'b0, 16'shc000, 16'sh0000,
                seq8(-16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384)};

    // Reset with random stimulus on every input.
    reset = 1'b1;
    for (int r = 0; r < 3; r++) begin
      bb.in_valid = 1'($urandom);
      bb.in_i     = 16'($urandom);
      bb.in_q     = 16'($urandom);
      lo_freq     = 26'($urandom);
      iq_swap     = 1'($urandom);
      step();
      check("rst_out", out, 0);
      check("rst_ready", bb.in_ready, 1);
      check("rst_underflow", underflow, 0);
    end
    cyc         = 0;
    reset       = 1'b0;
    bb.in_valid = 1'b0;
    lo_freq     = '0;
    iq_swap     = 1'b0;

    // Slot counter restarts: no strobe before the 32nd edge after release.
    uf_cnt  = 0;
    rdy_low = 0;
    repeat (31) begin
      step();
      if (underflow)    uf_cnt++;
      if (!bb.in_ready) rdy_low++;
    end
    check("no_early_strobe", uf_cnt, 0);
    check("idle_ready", rdy_low, 0);

    // Accept during the strobe cycle with the hold empty.
    bb.in_valid = 1'b1;
    bb.in_i     = 16'sh4000;
    bb.in_q     = 16'sh0000;
    step();
    check("first_strobe_underflow", underflow, 1);
    check("accept_on_strobe_ready", bb.in_ready, 0);
    bb.in_valid = 1'b0;
    step();
    check("underflow_one_cycle", underflow, 0);
    repeat (30) step();
    check("held_until_strobe", bb.in_ready, 0);
    step();
    check("consumed_ready", bb.in_ready, 1);
    check("consumed_no_underflow", underflow, 0);

    // Steady-state table: continuous source, fresh reset per vector.
    for (int k = 0; k < NV; k++) begin
      bb.in_valid = 1'b1;
      bb.in_i     = vecs[k].i;
      bb.in_q     = vecs[k].q;
      lo_freq     = vecs[k].f;
      iq_swap     = vecs[k].swap;
      do_reset(2);
      uf_cnt = 0;
      repeat (400) begin
        step();
        if (underflow) uf_cnt++;
      end
      check({vecs[k].name, "_underflow"}, uf_cnt, 0);
      for (int j = 0; j < 16; j++) begin
        step();
        e16 = vecs[k].exp[(cyc - 3) % 8];
        check({vecs[k].name, "_out"}, out, e16);
      end
    end

    // Source stops after steady state: periodic underflow, output decays.
    bb.in_valid = 1'b1;
    bb.in_i     = 16'sh4000;
    bb.in_q     = 16'sh0000;
    lo_freq     = '0;
    iq_swap     = 1'b0;
    do_reset(2);
    repeat (400) step();
    check("dc_pre_stop", out, 16383);
    for (int g = 0; g < 32 && (cyc % 32) != 5; g++) step();
    bb.in_valid = 1'b0;
    s0     = cyc - 5 + 32;
    uf_cnt = 0;
    repeat (128) begin
      step();
      if (cyc % 32 == 0) check("underflow_at_strobe", underflow, (cyc != s0) ? 1 : 0);
      else if (underflow) uf_cnt++;
    end
    check("underflow_off_strobe", uf_cnt, 0);
    repeat (200) step();
    for (int j = 0; j < 4; j++) begin
      step();
      check("decay_out", out, 0);
    end

    // Mid-stream reset pulse.
    bb.in_valid = 1'b1;
    repeat (400) step();
    check("dc_resume", out, 16383);
    reset = 1'b1;
    step();
    check("midrst_out", out, 0);
    check("midrst_ready", bb.in_ready, 1);
    check("midrst_underflow", underflow, 0);
    cyc   = 0;
    reset = 1'b0;
    step();
    check("post_reset_out", out, 0);
    repeat (400) step();
    check("dc_after_reset", out, 16383);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
